// File: rtl/unpacked_rr_arbiter_if.sv
// unpacked_rr_arbiter_if: request/data/grant/output-slot/counter bundle for the round-robin arbiter
interface unpacked_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
);
  logic           req [N];
  logic [W-1:0]   data [N];
  logic           gnt [N];
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           out_ready;
  logic           clr_cnt;
  logic [7:0]     gcnt [N];
  modport master (
    output req, data, out_ready, clr_cnt,
    input  gnt, out_valid, out_data, out_id, gcnt
  );
  modport slave (
    input  req, data, out_ready, clr_cnt,
    output gnt, out_valid, out_data, out_id, gcnt
  );
endinterface

// File: rtl/unpacked_rr_arbiter.sv
// unpacked_rr_arbiter: round-robin sharing of one registered output slot among N requesters
module unpacked_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input logic                  clock,
  input logic                  reset,
  unpacked_rr_arbiter_if.slave bus
);
  logic [IW-1:0] ptr_q, ptr_d, out_id_q, out_id_d, win;
  logic          out_valid_q, out_valid_d, hit, grant;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [7:0]    gcnt_q [N];
  logic [7:0]    gcnt_d [N];
  // pick the first requester at or after ptr, then derive grant and next state
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int j = N - 1; j >= 0; j--) begin
      int s;
      s = int'(ptr_q) + j;
      s = s >= N ? s - N : s;
      if (bus.req[IW'(s)]) begin
        hit = 1'b1;
        win = IW'(s);
      end
    end
    grant = hit && (!out_valid_q || bus.out_ready) && !reset;
    for (int i = 0; i < N; i++) bus.gnt[i] = grant && win == IW'(i);
    ptr_d       = grant ? (win == IW'(N - 1) ? '0 : win + 1'b1) : ptr_q;
    out_valid_d = grant || (out_valid_q && !bus.out_ready);
    out_data_d  = grant ? bus.data[win] : out_data_q;
    out_id_d    = grant ? win : out_id_q;
    for (int i = 0; i < N; i++)
      gcnt_d[i] = bus.clr_cnt ? 8'd0 :
                  (grant && win == IW'(i) && gcnt_q[i] != 8'hFF) ? gcnt_q[i] + 8'd1 : gcnt_q[i];
  end
  // register pointer, output slot and grant counters
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      for (int i = 0; i < N; i++) gcnt_q[i] <= 8'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      for (int i = 0; i < N; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.gcnt      = gcnt_q;
endmodule

// File: tb/tb_unpacked_rr_arbiter.sv
// tb_unpacked_rr_arbiter: directed and randomized checks of the round-robin arbiter against a queue-level model
module tb_unpacked_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  unpacked_rr_arbiter_if #(.N(N), .W(W)) bus ();
  unpacked_rr_arbiter #(.N(N), .W(W)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int          m_ptr;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_id;
  int          m_cnt [N];

  function automatic int pick();
    if (reset || (m_valid && !bus.out_ready)) return -1;
    for (int j = 0; j < N; j++)
      if (bus.req[(m_ptr + j) % N]) return (m_ptr + j) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] gvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = bus.gnt[i];
    return v;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    int k;
    k = pick();
    @(posedge clock);
    if (reset) begin
      m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (k >= 0) begin
        m_valid = 1; m_data = bus.data[k]; m_id = k; m_ptr = (k + 1) % N;
        m_cnt[k] = m_cnt[k] < 255 ? m_cnt[k] + 1 : 255;
      end else if (m_valid && bus.out_ready) m_valid = 0;
      if (bus.clr_cnt) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) bus.req[i] = r[i];
    #1;
  endtask

  task automatic test_reset();
    reset = 1; bus.out_ready = 0; bus.clr_cnt = 0;
    for (int i = 0; i < N; i++) bus.data[i] = 8'hA0 + 8'(i);
    set_req('1);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (gvec() !== '0) $display("FAIL reset_gnt cycle %0d: got %b want 0", c, gvec()); else passes++;
      tick();
    end
    reset = 0; bus.out_ready = 1;
    set_req('0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_id !== '0)
      $display("FAIL reset_out: valid=%b id=%0d want 0/0", bus.out_valid, bus.out_id); else passes++;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (bus.gcnt[i] !== 8'd0) $display("FAIL reset_gcnt[%0d]: got %0d want 0", i, bus.gcnt[i]); else passes++;
    end
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    set_req('1);
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (gvec() !== onehot(order[s])) $display("FAIL rot_gnt step %0d: got %b want %b", s, gvec(), onehot(order[s])); else passes++;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA0 + 8'(order[s]))
        $display("FAIL rot_data step %0d: got %b/%h want 1/%h", s, bus.out_valid, bus.out_data, 8'hA0 + 8'(order[s])); else passes++;
    end
    checks++;
    if (bus.gcnt[0] !== 8'd2) $display("FAIL rot_gcnt0: got %0d want 2", bus.gcnt[0]); else passes++;
  endtask

  task automatic test_stall_skip();
    set_req(4'b1010);
    checks++;
    if (gvec() !== 4'b0010) $display("FAIL stall_first: got %b want 0010", gvec()); else passes++;
    tick();
    bus.out_ready = 0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (gvec() !== '0) $display("FAIL stall_gnt cycle %0d: got %b want 0", c, gvec()); else passes++;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1)
        $display("FAIL stall_hold cycle %0d: valid=%b id=%0d want 1/1", c, bus.out_valid, bus.out_id); else passes++;
    end
    bus.out_ready = 1; #1;
    checks++;
    if (gvec() !== 4'b1000) $display("FAIL skip_3: got %b want 1000", gvec()); else passes++;
    tick();
    checks++;
    if (gvec() !== 4'b0010) $display("FAIL skip_1: got %b want 0010", gvec()); else passes++;
    tick();
  endtask

  task automatic test_wrap();
    set_req(4'b0100);
    tick();
    set_req(4'b1001);
    checks++;
    if (gvec() !== 4'b1000) $display("FAIL wrap_3: got %b want 1000", gvec()); else passes++;
    tick();
    checks++;
    if (gvec() !== 4'b0001) $display("FAIL wrap_0: got %b want 0001", gvec()); else passes++;
    tick();
    set_req('1);
    checks++;
    if (gvec() !== 4'b0010) $display("FAIL wrap_ptr1: got %b want 0010", gvec()); else passes++;
    tick();
  endtask

  task automatic test_saturation();
    set_req(4'b0001);
    for (int c = 0; c < 300; c++) tick();
    checks++;
    if (bus.gcnt[0] !== 8'd255) $display("FAIL sat_gcnt0: got %0d want 255", bus.gcnt[0]); else passes++;
    bus.clr_cnt = 1; #1;
    checks++;
    if (gvec() !== 4'b0001) $display("FAIL clr_gnt: got %b want 0001", gvec()); else passes++;
    tick();
    bus.clr_cnt = 0;
    checks++;
    if (bus.gcnt[0] !== 8'd0) $display("FAIL clr_gcnt0: got %0d want 0", bus.gcnt[0]); else passes++;
  endtask

  task automatic test_reset_mid();
    set_req(4'b0100);
    tick();
    bus.out_ready = 0;
    set_req('0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2)
      $display("FAIL mid_setup: valid=%b id=%0d want 1/2", bus.out_valid, bus.out_id); else passes++;
    reset = 1;
    set_req('1);
    checks++;
    if (gvec() !== '0) $display("FAIL mid_reset_gnt: got %b want 0", gvec()); else passes++;
    tick();
    reset = 0; bus.out_ready = 1; #1;
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.out_valid); else passes++;
    checks++;
    if (gvec() !== 4'b0001) $display("FAIL mid_first_gnt: got %b want 0001", gvec()); else passes++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = $urandom_range(0, 63) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.clr_cnt = $urandom_range(0, 31) == 0;
      for (int i = 0; i < N; i++) bus.data[i] = 8'($urandom);
      set_req(N'($urandom));
      checks++;
      if (gvec() !== onehot(pick())) $display("FAIL rnd_gnt cycle %0d: got %b want %b", c, gvec(), onehot(pick())); else passes++;
      tick();
      checks++;
      if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_id !== 2'(m_id))
        $display("FAIL rnd_out cycle %0d: got %b/%h/%0d want %b/%h/%0d", c, bus.out_valid, bus.out_data, bus.out_id, m_valid, m_data, m_id);
      else passes++;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (bus.gcnt[i] !== 8'(m_cnt[i])) $display("FAIL rnd_gcnt[%0d] cycle %0d: got %0d want %0d", i, c, bus.gcnt[i], m_cnt[i]); else passes++;
      end
    end
    reset = 0; bus.clr_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall_skip();
    test_wrap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/unpacked_rr_arbiter.md
# unpacked_rr_arbiter

Round-robin arbiter sharing one registered output slot among N requesters. Requests, data, grants and grant counters are all unpacked-array ports (IEEE 1800-2017 7.4.2 size-style declarations), so the block exercises unpacked arrays on ports through real sequential logic. It sits in the systemverilog test suite next to the other unpacked-array port cases. It is the sequencing/sharing stage for M-wide data feeding unpacked-array consumers.

## Interface

Parameters:
- N, 4, number of requesters; legal range 2..16.
- W, 8, data width per requester.
- IW, $clog2(N), width of the granted-requester id; derived, not to be overridden.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  logic req [N]  per-requester request; held high until granted.
- data  input  logic [W-1:0] data [N]  per-requester payload; stable while req is high.
- gnt  output  logic gnt [N]  one-hot grant; combinational; gnt[i]=1 means data[i] is captured at this edge.
- out_valid  output  1  output slot holds a word.
- out_data  output  W  payload of the held word.
- out_id  output  IW  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the held word when out_valid && out_ready.
- clr_cnt  input  1  synchronous clear of all grant counters.
- gcnt  output  logic [7:0] gcnt [N]  per-requester saturating grant counters.

## Operation

- State: ptr (IW bits, highest-priority index), out_valid/out_data/out_id register, gcnt[N].
- Slot free condition: free = !out_valid || out_ready.
- Arbitration: when free, scan req starting at ptr, wrapping modulo N; the first asserted index k wins. gnt[k]=1, all other gnt=0. When not free or no req, all gnt=0.
- On a grant to k at the edge:
  - out_valid<=1, out_data<=data[k], out_id<=k.
  - ptr<=(k+1) mod N. The wrap from N-1 goes to 0.
  - gcnt[k] increments and saturates at 255.
- Pop without grant (out_valid && out_ready, no req): out_valid<=0. out_data and out_id hold their last values.
- Back-to-back: a pop and a new grant in the same cycle load the new word with out_valid staying 1. Throughput is one word per cycle.
- Stall: when out_valid && !out_ready, gnt stays all-zero and out_* hold. Requesters wait with req high, and ptr does not move.
- ptr moves only on a grant. It never moves on idle cycles.
- clr_cnt: all gcnt<=0. If a grant coincides with clr_cnt, clr_cnt wins and the granted counter also reads 0.
- Reset, including mid-operation:
  - out_valid=0, out_data=0, out_id=0, ptr=0, all gcnt=0.
  - Any held word is dropped.
  - gnt is all-zero during every cycle in which reset is high, whatever req is.

## Timing

- gnt is combinational from req, ptr, out_valid and out_ready, with no input-to-register delay. Requesters sample gnt in the same cycle.
- Latency from a grant edge to out_valid=1 is 1 cycle.
- Minimum req-to-out_valid latency is 1 cycle, when the slot is free.
- Worst-case wait for a continuously requesting input is N-1 grants to the others, plus any stall cycles.
- gcnt updates are visible 1 cycle after the grant edge.
- No combinational path runs from out_ready to out_valid/out_data. Both are registered.

## Test plan

- Reset then idle:
  - Stimulus: assert reset for 2 cycles with all req=1, then deassert with out_ready=1 and req all 0.
  - Required: gnt all 0 during reset; out_valid=0, out_id=0 and all gcnt=0 after reset.
- Rotation, N=4:
  - Stimulus: req={1,1,1,1} held, data[i]=8'hA0+i, out_ready=1.
  - Required: grants in order 0,1,2,3,0; out_data sequence A0,A1,A2,A3,A0 on consecutive cycles; gcnt[0]=2 after 5 grants.
- Stall and skip:
  - Stimulus: req[1] and req[3] only, out_ready=0 after the first grant.
  - Required: grant 1 is issued; out_valid holds with out_id=1; gnt all 0 for the 3 stall cycles; once out_ready=1, the next grant is 3, then 1.
- Wrap-around:
  - Stimulus: ptr=3 after a grant to 2; then req={1,0,0,1}.
  - Required: grant 3, then 0, so ptr goes 3→0→1.
- Counter saturation and clear:
  - Stimulus: 300 grants to requester 0 alone, then clr_cnt=1 coincident with a grant.
  - Required: gcnt[0] stops at 255 and then reads 0 the cycle after the clear.
- Reset mid-operation:
  - Stimulus: out_valid=1, out_id=2, out_ready=0; assert reset for 1 cycle.
  - Required: out_valid=0 on the next cycle; the first post-reset grant with all req=1 goes to 0.
